// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: DataMemory size codes and the queued-store record.
package sb_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_BYTE  = 3'b001;
  localparam logic [2:0] DM_HALF  = 3'b010;
  localparam logic [2:0] DM_BYTEU = 3'b100;
  localparam logic [2:0] DM_HALFU = 3'b101;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [2:0]       ctrl;
  } sb_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Entry storage for the store buffer: circular queue with per-entry valid bits,
// read/write pointers and an occupancy count.
module store_buf_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [AW-1:0]                    push_addr,
  input  logic [DW-1:0]                    push_data,
  input  logic [2:0]                       push_ctrl,
  input  logic                             pop,
  output logic [AW-1:0]                    head_addr,
  output logic [DW-1:0]                    head_data,
  output logic [2:0]                       head_ctrl,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][AW-1:0]         ent_addr,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             full,
  output logic                             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0]  data_q, data_d;
  logic [DEPTH-1:0][2:0]     ctrl_q, ctrl_d;

  // Push and pop never target the same slot: that only happens when full
  // (push blocked) or empty (pop blocked).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = push_addr;
      data_d[wr_ptr_q]  = push_data;
      ctrl_d[wr_ptr_q]  = push_ctrl;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    ctrl_q <= ctrl_d;
  end

  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign head_ctrl = ctrl_q[rd_ptr_q];
  assign ent_valid = valid_q;
  assign ent_addr  = addr_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of DataMemory: word-granular RAW stall, drains on load-free cycles.
// Optional STORE_BUF_STATS_EN adds saturating stall_cnt / drain_cnt outputs.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  input  logic [2:0]             st_ctrl,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  input  logic [2:0]             ld_ctrl,
  output logic                   ld_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   DMWr,
  output logic [2:0]             DMCtrl,
  output logic [AW-1:0]          Address,
  output logic [DW-1:0]          DataWr
`ifdef STORE_BUF_STATS_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            drain_cnt
`endif
);

  // Handshake: a store transfers at a rising edge where st_valid && st_ready;
  // a load is accepted in any cycle where ld_valid && !ld_stall, otherwise the
  // core holds it unchanged and retries next cycle.

  logic                     push, pop, full, empty;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [2:0]               head_ctrl;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         match;
  logic                     hazard, drain;

  store_buf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (st_addr),
    .push_data (st_data),
    .push_ctrl (st_ctrl),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_ctrl (head_ctrl),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Word-granular overlap against queued entries only.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ent_valid[i] && (ent_addr[i][AW-1:2] == ld_addr[AW-1:2]);
    end
  end

  assign hazard   = ld_valid && (|match);
  assign drain    = rst_n && !empty && (!ld_valid || hazard);
  assign push     = st_valid && !full;
  assign pop      = drain;
  assign st_ready = !full;
  assign ld_stall = rst_n && hazard;

  always_comb begin
    DMWr    = 1'b0;
    DMCtrl  = DM_WORD;
    Address = '0;
    DataWr  = '0;
    if (drain) begin
      DMWr    = 1'b1;
      DMCtrl  = head_ctrl;
      Address = head_addr;
      DataWr  = head_data;
    end else if (rst_n && ld_valid) begin
      DMCtrl  = ld_ctrl;
      Address = ld_addr;
    end
  end

`ifdef STORE_BUF_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (ld_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (drain && (drain_cnt_q != 16'hFFFF))    drain_cnt_d = drain_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign drain_cnt = drain_cnt_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random store/load traffic against a queue model.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_ctrl = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_ctrl = '0;
  logic        ld_stall;
  logic [2:0]  count;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] Address;
  logic [31:0] DataWr;
`ifdef STORE_BUF_STATS_EN
  logic [15:0] stall_cnt, drain_cnt;
`endif

  int checks = 0;
  int failures = 0;
  sb_entry_t exp_q[$];
  int stall_exp = 0;
  int drain_exp = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_ctrl(st_ctrl),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ctrl(ld_ctrl), .ld_stall(ld_stall),
    .count(count), .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address), .DataWr(DataWr)
`ifdef STORE_BUF_STATS_EN
    , .stall_cnt(stall_cnt), .drain_cnt(drain_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Asynchronous reset in mid-cycle with a load presented; outputs must be quiet at once.
  task automatic do_reset();
    ld_valid = 1'b1;
    ld_addr  = 32'h40;
    ld_ctrl  = DM_HALF;
    st_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_DMWr", {31'b0, DMWr}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_st_ready", {31'b0, st_ready}, 32'd1);
    check("rst_Address", Address, 32'd0);
    check("rst_DataWr", DataWr, 32'd0);
    check("rst_DMCtrl", {29'b0, DMCtrl}, 32'd0);
    exp_q.delete();
    stall_exp = 0;
    drain_exp = 0;
    @(negedge clk);
    ld_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive inputs, compare against the queue model, advance model at the edge.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sc,
                       input logic lv, input logic [31:0] la, input logic [2:0] lc);
    logic      stall_e, drain_e, accept_e;
    sb_entry_t h, n;
    st_valid = sv; st_addr = sa; st_data = sd; st_ctrl = sc;
    ld_valid = lv; ld_addr = la; ld_ctrl = lc;
    #2;
    stall_e = 1'b0;
    foreach (exp_q[i]) if (lv && exp_q[i].addr[31:2] == la[31:2]) stall_e = 1'b1;
    drain_e  = (exp_q.size() != 0) && (!lv || stall_e);
    accept_e = sv && (exp_q.size() < DEPTH);
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("ld_stall", {31'b0, ld_stall}, {31'b0, stall_e});
    check("st_ready", {31'b0, st_ready}, {31'b0, exp_q.size() < DEPTH});
    check("count", {29'b0, count}, exp_q.size());
    check("DMWr", {31'b0, DMWr}, {31'b0, drain_e});
    check("Address", Address, drain_e ? h.addr : (lv ? la : 32'd0));
    check("DataWr", DataWr, drain_e ? h.data : 32'd0);
    check("DMCtrl", {29'b0, DMCtrl}, {29'b0, drain_e ? h.ctrl : (lv ? lc : 3'b000)});
    @(posedge clk);
    if (stall_e) stall_exp++;
    if (drain_e) begin
      void'(exp_q.pop_front());
      drain_exp++;
    end
    if (accept_e) begin
      n.addr = sa; n.data = sd; n.ctrl = sc;
      exp_q.push_back(n);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0);
  endtask

  initial begin
    do_reset();

    // single store, drained next cycle
    cycle(1'b1, 32'h0, 32'hABCD1234, DM_WORD, 1'b0, 32'd0, 3'd0);
    idle(2);

    // fill under a non-conflicting load, then drain in order
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), DM_WORD, 1'b1, 32'h100, DM_WORD);
    cycle(1'b1, 32'h50, 32'hDEAD, DM_WORD, 1'b1, 32'h100, DM_WORD);
    idle(5);

    // RAW hazard: byte store then overlapping half load
    cycle(1'b1, 32'h4, 32'hFF, DM_BYTE, 1'b0, 32'd0, 3'd0);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0);
    cycle(1'b1, 32'h4, 32'hFF, DM_BYTE, 1'b1, 32'h100, DM_WORD);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h6, DM_HALFU);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h6, DM_HALFU);
    idle(1);

    // concurrent push/pop at count=2
    cycle(1'b1, 32'h20, 32'h11, DM_WORD, 1'b1, 32'h200, DM_WORD);
    cycle(1'b1, 32'h24, 32'h22, DM_WORD, 1'b1, 32'h200, DM_WORD);
    cycle(1'b1, 32'h8, 32'hFFFF, DM_HALF, 1'b0, 32'd0, 3'd0);
    idle(4);

    // reset mid-drain with three pending stores, then quiet port
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h30 + 32'(4 * i), 32'h77 + 32'(i), DM_WORD, 1'b1, 32'h300, DM_WORD);
    do_reset();
    idle(5);

    // random traffic over a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if (op == 1)
        cycle(1'b1, a, $urandom, 3'($urandom_range(0, 5)), 1'b0, 32'd0, 3'd0);
      else if (op == 2)
        cycle(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, a, 3'($urandom_range(0, 5)));
      else
        idle(1);
    end
    idle(6);

`ifdef STORE_BUF_STATS_EN
    check("stall_cnt", {16'b0, stall_cnt}, 32'(stall_exp));
    check("drain_cnt", {16'b0, drain_cnt}, 32'(drain_exp));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
